instr_encoder_loader: RTL and testbench

- Boot-time program loader: accepts decoded-form instruction descriptors (class, registers, funct3, immediate) over a valid/ready stream.
- Packs each descriptor into a 32-bit RV32I instruction word (R/I/S/B/U/J formats) covering the opcode set the core's main decoder supports.
- Writes each word sequentially into the instruction memory write port.
- Range-checks immediates and stops with a sticky error code on any illegal descriptor or memory overflow.

---
 rtl/rv_enc_pkg.sv | 49 ++++
 rtl/rv_instr_pack.sv | 83 ++++++++
 rtl/instr_encoder_loader.sv | 126 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32I program loader.
// Holds descriptor class codes, base opcodes (also usable by the core's
// main decoder), loader error codes, the loader FSM state encoding and a
// signed range helper.
package rv_enc_pkg;

    // Descriptor class codes (9..15 are illegal)
    localparam logic [3:0] CLS_LOAD   = 4'd0;
    localparam logic [3:0] CLS_STORE  = 4'd1;
    localparam logic [3:0] CLS_RTYPE  = 4'd2;
    localparam logic [3:0] CLS_BRANCH = 4'd3;
    localparam logic [3:0] CLS_ITYPE  = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_LUI    = 4'd6;
    localparam logic [3:0] CLS_AUIPC  = 4'd7;
    localparam logic [3:0] CLS_JALR   = 4'd8;

    // RV32I base opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Loader error codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // True when lo <= v <= hi (signed)
    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I instruction packer.
// Ports:
//   cls, rd, rs1, rs2, funct3, alt, imm : decoded descriptor
//   word      : packed 32-bit instruction
//   illegal   : unsupported class or funct3 for that class
//   range_err : immediate outside the encodable range / misaligned
// Both flags may be set together; the consumer decides priority.
module rv_instr_pack
    import rv_enc_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        range_err
);

    logic signed [31:0] simm;
    assign simm = imm;

    always_comb begin
        word      = '0;
        illegal   = 1'b0;
        range_err = 1'b0;
        case (cls)
            CLS_LOAD: begin
                // legal widths: LB LH LW LBU LHU
                illegal   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                range_err = !in_range(simm, -32'sd2048, 32'sd2047);
                word      = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            end
            CLS_STORE: begin
                illegal   = (funct3 > 3'b010);
                range_err = !in_range(simm, -32'sd2048, 32'sd2047);
                word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            end
            CLS_RTYPE: begin
                word = {(alt ? 7'b0100000 : 7'b0000000), rs2, rs1, funct3, rd, OP_RTYPE};
            end
            CLS_BRANCH: begin
                illegal   = (funct3[2:1] == 2'b01);
                range_err = !in_range(simm, -32'sd4096, 32'sd4094) || imm[0];
                word      = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], OP_BRANCH};
            end
            CLS_ITYPE: begin
                if (funct3[1:0] == 2'b01) begin
                    // SLLI/SRLI/SRAI: shamt is an unsigned 5-bit field
                    range_err = |imm[31:5];
                    word      = {1'b0, alt, 5'b00000, imm[4:0], rs1, funct3, rd, OP_ITYPE};
                end else begin
                    range_err = !in_range(simm, -32'sd2048, 32'sd2047);
                    word      = {imm[11:0], rs1, funct3, rd, OP_ITYPE};
                end
            end
            CLS_JAL: begin
                range_err = !in_range(simm, -32'sd1048576, 32'sd1048574) || imm[0];
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            CLS_LUI: begin
                range_err = |imm[11:0];
                word      = {imm[31:12], rd, OP_LUI};
            end
            CLS_AUIPC: begin
                range_err = |imm[11:0];
                word      = {imm[31:12], rd, OP_AUIPC};
            end
            CLS_JALR: begin
                range_err = !in_range(simm, -32'sd2048, 32'sd2047);
                word      = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-time program loader: accepts instruction descriptors on a
// valid/ready stream, packs them into RV32I words and writes them
// sequentially into instruction memory starting at BASE_ADDR.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : descriptor handshake (ready only in IDLE)
//   in_class..in_imm      : descriptor fields, in_last marks the final one
//   mem_we/addr/wdata     : instruction memory write port
//   load_done             : program fully written (sticky until reset)
//   enc_error, err_code   : sticky error flag and cause
module instr_encoder_loader
    import rv_enc_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              load_done,
    output logic              enc_error,
    output logic [1:0]        err_code
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [31:0]        word_r;
    logic               last_r;
    logic [31:0]        pack_word;
    logic               pack_illegal;
    logic               pack_range;
    logic               at_limit;

    rv_instr_pack u_pack (
        .cls       (in_class),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .alt       (in_alt),
        .imm       (in_imm),
        .word      (pack_word),
        .illegal   (pack_illegal),
        .range_err (pack_range)
    );

    // The word being written now is the last one that fits
    assign at_limit  = (32'(count) + 32'd1) == DEPTH;
    assign mem_wdata = word_r;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        load_done  = 1'b0;
        enc_error  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (pack_illegal || pack_range) ? ST_ERROR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (last_r)        state_next = ST_DONE;
                else if (at_limit) state_next = ST_ERROR;
                else               state_next = ST_IDLE;
            end
            ST_DONE: begin
                load_done = 1'b1;
            end
            ST_ERROR: begin
                enc_error = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            mem_addr <= ADDR_W'(BASE_ADDR);
            word_r   <= '0;
            last_r   <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && in_valid) begin
                // illegal descriptor outranks a range fault
                if (pack_illegal) begin
                    err_code <= ERR_ILLEGAL;
                end else if (pack_range) begin
                    err_code <= ERR_RANGE;
                end else begin
                    word_r <= pack_word;
                    last_r <= in_last;
                end
            end
            if (state == ST_WRITE) begin
                count    <= count + 1'b1;
                mem_addr <= mem_addr + ADDR_W'(4);
                if (!last_r && at_limit) err_code <= ERR_OVERFLOW;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
    } desc_t;

    typedef struct {
        desc_t       d;
        logic [31:0] w;
        int          code;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_class = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_alt = 1'b0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;

    logic        in_ready, mem_we, load_done, enc_error;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  err_code;

    logic        ready4, we4, done4, error4;
    logic [9:0]  addr4;
    logic [31:0] wdata4;
    logic [1:0]  code4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(256)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_done(load_done), .enc_error(enc_error), .err_code(err_code)
    );

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready4),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .in_last(in_last),
        .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
        .load_done(done4), .enc_error(error4), .err_code(code4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic desc_t mk(input int cls, input int rd, input int rs1, input int rs2,
                                 input int f3, input int alt, input logic [31:0] imm);
        desc_t d;
        d.cls = 4'(cls); d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
        d.f3 = 3'(f3); d.alt = 1'(alt); d.imm = imm;
        return d;
    endfunction

    // Reference encoder: fields placed with shifts/masks from the ISA tables
    function automatic void model(input desc_t d, output logic [31:0] w, output int code);
        logic [31:0] u;
        int s;
        logic [31:0] rd, rs1, rs2, f3;
        u = d.imm; s = $signed(u);
        rd = 32'(d.rd) << 7; rs1 = 32'(d.rs1) << 15; rs2 = 32'(d.rs2) << 20; f3 = 32'(d.f3) << 12;
        w = 0; code = 0;
        case (d.cls)
            0: begin
                if (d.f3 == 3 || d.f3 >= 6) code = 1;
                else if (s < -2048 || s > 2047) code = 2;
                w = ((u & 32'hfff) << 20) | rs1 | f3 | rd | 32'h03;
            end
            1: begin
                if (d.f3 > 2) code = 1;
                else if (s < -2048 || s > 2047) code = 2;
                w = (((u >> 5) & 32'h7f) << 25) | rs2 | rs1 | f3 | ((u & 32'h1f) << 7) | 32'h23;
            end
            2: w = (d.alt ? 32'h40000000 : 32'h0) | rs2 | rs1 | f3 | rd | 32'h33;
            3: begin
                if (d.f3 == 2 || d.f3 == 3) code = 1;
                else if (s < -4096 || s > 4094 || (s % 2) != 0) code = 2;
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | rs2 | rs1 | f3 |
                    (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            end
            4: begin
                if (d.f3 == 1 || d.f3 == 5) begin
                    if (u > 31) code = 2;
                    w = (d.alt ? 32'h40000000 : 32'h0) | ((u & 32'h1f) << 20) | rs1 | f3 | rd | 32'h13;
                end else begin
                    if (s < -2048 || s > 2047) code = 2;
                    w = ((u & 32'hfff) << 20) | rs1 | f3 | rd | 32'h13;
                end
            end
            5: begin
                if (s < -1048576 || s > 1048574 || (s % 2) != 0) code = 2;
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 1) << 20) |
                    (((u >> 12) & 32'hff) << 12) | rd | 32'h6f;
            end
            6, 7: begin
                if ((u & 32'hfff) != 0) code = 2;
                w = (u & 32'hfffff000) | rd | ((d.cls == 6) ? 32'h37 : 32'h17);
            end
            8: begin
                if (s < -2048 || s > 2047) code = 2;
                w = ((u & 32'hfff) << 20) | rs1 | rd | 32'h67;
            end
            default: code = 1;
        endcase
    endfunction

    task automatic drive(input desc_t d, input logic last);
        in_class = d.cls; in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2;
        in_funct3 = d.f3; in_alt = d.alt; in_imm = d.imm; in_last = last;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one descriptor at a negedge and check the write/error that follows
    task automatic send_chk(input string nm, input desc_t d, input logic last,
                            input logic [31:0] ew, input int code, input logic [9:0] eaddr);
        chk({nm, ".ready"}, 32'(in_ready), 1);
        drive(d, last);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (code == 0) begin
            chk({nm, ".we"}, 32'(mem_we), 1);
            chk({nm, ".data"}, mem_wdata, ew);
            chk({nm, ".addr"}, 32'(mem_addr), 32'(eaddr));
            @(negedge clk);
            chk({nm, ".we_off"}, 32'(mem_we), 0);
            chk({nm, ".addr_next"}, 32'(mem_addr), 32'(eaddr) + 4);
        end else begin
            chk({nm, ".no_we"}, 32'(mem_we), 0);
            chk({nm, ".enc_error"}, 32'(enc_error), 1);
            chk({nm, ".err_code"}, 32'(err_code), 32'(code));
            chk({nm, ".err_ready"}, 32'(in_ready), 0);
        end
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] b[13];
        b = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, -32'sd4096,
              32'd31, 32'd32, 32'd0, 32'd1048574, -32'sd1048576, 32'd1048576};
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 4095)) - 32'd2048;
            1: return b[$urandom_range(0, 12)];
            2: return $urandom;
            default: return $urandom & 32'hfffff000;
        endcase
    endfunction

    vec_t tbl[18];

    initial begin
        int pulses;
        logic [31:0] w;
        int code;
        desc_t d;

        tbl[0]  = '{mk(4, 1, 0, 0, 0, 0, 32'd5),            32'h00500093, 0};
        tbl[1]  = '{mk(4, 1, 0, 0, 0, 0, 32'd2048),         32'h0,        2};
        tbl[2]  = '{mk(9, 1, 0, 0, 0, 0, 32'd0),            32'h0,        1};
        tbl[3]  = '{mk(3, 0, 1, 2, 0, 0, 32'd3),            32'h0,        2};
        tbl[4]  = '{mk(0, 1, 2, 0, 3, 0, 32'd4000),         32'h0,        1};
        tbl[5]  = '{mk(1, 0, 1, 2, 3, 0, 32'd8),            32'h0,        1};
        tbl[6]  = '{mk(4, 3, 4, 0, 1, 0, 32'd31),           32'h01F21193, 0};
        tbl[7]  = '{mk(4, 3, 4, 0, 5, 1, 32'd32),           32'h0,        2};
        tbl[8]  = '{mk(4, 3, 4, 0, 5, 1, 32'd5),            32'h40525193, 0};
        tbl[9]  = '{mk(2, 5, 6, 7, 0, 1, 32'd0),            32'h407302B3, 0};
        tbl[10] = '{mk(8, 1, 5, 0, 7, 0, -32'sd2048),       32'h800280E7, 0};
        tbl[11] = '{mk(6, 5, 0, 0, 0, 0, 32'h12345001),     32'h0,        2};
        tbl[12] = '{mk(5, 1, 0, 0, 0, 0, 32'd1048576),      32'h0,        2};
        tbl[13] = '{mk(5, 1, 0, 0, 0, 0, -32'sd1048576),    32'h800000EF, 0};
        tbl[14] = '{mk(3, 0, 1, 2, 2, 0, 32'd4),            32'h0,        1};
        tbl[15] = '{mk(7, 7, 0, 0, 0, 0, 32'hFFFFF000),     32'hFFFFF397, 0};
        tbl[16] = '{mk(3, 0, 0, 0, 1, 0, 32'd4094),         32'h7E001FE3, 0};
        tbl[17] = '{mk(0, 1, 2, 0, 2, 0, -32'sd2049),       32'h0,        2};

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst.ready", 32'(in_ready), 1);
        chk("rst.we", 32'(mem_we), 0);
        chk("rst.addr", 32'(mem_addr), 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.done", 32'(load_done), 0);
        chk("rst.error", 32'(enc_error), 0);
        chk("rst.code", 32'(err_code), 0);

        // Single-descriptor table, last=1
        for (int i = 0; i < 18; i++) begin
            do_reset();
            send_chk($sformatf("tbl%0d", i), tbl[i].d, 1'b1, tbl[i].w, tbl[i].code, 10'h000);
            if (tbl[i].code == 0) chk($sformatf("tbl%0d.done", i), 32'(load_done), 1);
        end

        // addi then in_ready back
        do_reset();
        send_chk("addi", mk(4, 1, 0, 0, 0, 0, 32'd5), 1'b0, 32'h00500093, 0, 10'h000);
        chk("addi.ready_back", 32'(in_ready), 1);

        // sw then beq (last)
        do_reset();
        send_chk("sw", mk(1, 0, 1, 2, 2, 0, 32'd8), 1'b0, 32'h0020A423, 0, 10'h000);
        send_chk("beq", mk(3, 0, 1, 2, 0, 0, -32'sd4), 1'b1, 32'hFE208EE3, 0, 10'h004);
        chk("beq.done", 32'(load_done), 1);
        chk("beq.ready", 32'(in_ready), 0);

        // lui then jal (last)
        do_reset();
        send_chk("lui", mk(6, 5, 0, 0, 0, 0, 32'h12345000), 1'b0, 32'h123452B7, 0, 10'h000);
        send_chk("jal", mk(5, 1, 0, 0, 0, 0, 32'h800), 1'b1, 32'h001000EF, 0, 10'h004);
        chk("jal.done", 32'(load_done), 1);

        // Range error, sticky, then reset restarts at BASE_ADDR
        do_reset();
        send_chk("addi2048", mk(4, 1, 0, 0, 0, 0, 32'd2048), 1'b0, 32'h0, 2, 10'h000);
        drive(mk(4, 1, 0, 0, 0, 0, 32'd5), 1'b0);
        in_valid = 1'b1;
        pulses = 0;
        repeat (3) begin @(negedge clk); if (mem_we) pulses++; end
        in_valid = 1'b0;
        chk("err.sticky_code", 32'(err_code), 2);
        chk("err.sticky_ready", 32'(in_ready), 0);
        chk("err.no_writes", 32'(pulses), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("err_rst.ready", 32'(in_ready), 1);
        chk("err_rst.error", 32'(enc_error), 0);
        chk("err_rst.code", 32'(err_code), 0);
        chk("err_rst.addr", 32'(mem_addr), 0);
        chk("err_rst.wdata", mem_wdata, 0);
        send_chk("after_rst", mk(4, 2, 0, 0, 0, 0, 32'd5), 1'b0, 32'h00500113, 0, 10'h000);

        // in_valid held across the WRITE cycle: one write only
        do_reset();
        drive(mk(4, 1, 0, 0, 0, 0, 32'd5), 1'b0);
        in_valid = 1'b1;
        pulses = 0;
        @(negedge clk); if (mem_we) pulses++;
        @(negedge clk); if (mem_we) pulses++;
        in_valid = 1'b0;
        repeat (3) begin @(negedge clk); if (mem_we) pulses++; end
        chk("hold.pulses", 32'(pulses), 1);
        chk("hold.addr", 32'(mem_addr), 4);

        // DEPTH=4 overflow
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf%0d.ready", i), 32'(ready4), 1);
            drive(mk(4, i + 1, 0, 0, 0, 0, 32'(i)), 1'b0);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("ovf%0d.we", i), 32'(we4), 1);
            chk($sformatf("ovf%0d.addr", i), 32'(addr4), 32'(i * 4));
            @(negedge clk);
        end
        chk("ovf.error", 32'(error4), 1);
        chk("ovf.code", 32'(code4), 3);
        chk("ovf.ready", 32'(ready4), 0);
        drive(mk(4, 5, 0, 0, 0, 0, 32'd4), 1'b0);
        in_valid = 1'b1;
        pulses = 0;
        repeat (3) begin @(negedge clk); if (we4) pulses++; end
        in_valid = 1'b0;
        chk("ovf.fifth_ignored", 32'(pulses), 0);
        chk("ovf.code_kept", 32'(code4), 3);

        // Randomized programs vs reference model
        for (int p = 0; p < 40; p++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                d = mk($urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1), rand_imm());
                model(d, w, code);
                send_chk($sformatf("rnd%0d_%0d", p, k), d, k == n - 1, w, code, 10'(k * 4));
                if (code != 0) break;
                if (k == n - 1) begin
                    chk($sformatf("rnd%0d.done", p), 32'(load_done), 1);
                    chk($sformatf("rnd%0d.ready", p), 32'(in_ready), 0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
